// File: rtl/prog_instruction_memory.sv
// prog_instruction_memory: streaming-loaded instruction store with a registered fetch port
module prog_instruction_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  input  logic              i_load_end,
  output logic [ADDR_W-1:0] o_load_ptr,
  output logic [ADDR_W:0]   o_prog_len,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_instr_out,
  output logic              o_instr_valid,
  output logic              o_fetch_fault,
  output logic              o_state_run
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_load_ptr;
  logic [ADDR_W:0] r_prog_len;
  logic [DATA_W-1:0] r_instr;
  logic r_valid, r_fault;
  logic w_full, w_accept, w_hit, w_fetch;
  assign w_full = r_prog_len == LEN_MAX;
  assign o_load_ready = (r_state == LOAD) && (r_prog_len < LEN_MAX);
  assign w_accept = i_load_valid && o_load_ready;
  assign w_hit = {1'b0, i_pc} < r_prog_len;
  assign w_fetch = i_fetch_req && (r_state == RUN);
  assign o_load_ptr = r_load_ptr;
  assign o_prog_len = r_prog_len;
  assign o_instr_out = r_instr;
  assign o_instr_valid = r_valid;
  assign o_fetch_fault = r_fault;
  assign o_state_run = r_state == RUN;
  // next state: load_start always (re)enters LOAD; LOAD leaves on load_end or once the store is full
  always_comb begin
    w_next = i_load_start ? LOAD : ((r_state == LOAD) && (i_load_end || w_full)) ? RUN : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // loader: write at the pointer on each accepted word; pointer parks on the last slot when full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_ptr <= '0;
      r_prog_len <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_load_start) begin
      r_load_ptr <= '0;
      r_prog_len <= '0;
    end else if (w_accept) begin
      r_mem[r_load_ptr] <= i_load_data;
      r_prog_len <= r_prog_len + 1'b1;
      if (r_prog_len != LEN_MAX - 1'b1) r_load_ptr <= r_load_ptr + 1'b1;
    end
  end
  // fetch port: one-cycle registered read; unloaded addresses return the NOP word with a fault
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_valid <= w_fetch;
      r_fault <= w_fetch && !w_hit;
      if (w_fetch) r_instr <= w_hit ? r_mem[i_pc] : NOP_WORD;
    end
  end
endmodule
